// File: rtl/serial_word_feeder.sv
// Buffers parallel words in a small FIFO and serializes them MSB-first, one bit per clock.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_feeder #(
    parameter int   WIDTH    = 8,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     out,
    output logic                     bit_valid,
    output logic                     word_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SERIAL_FEEDER_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop, end_frame;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             out_next, bit_valid_next, word_done_next;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             par, par_next;
`endif

    // Space is judged on occupancy alone, so a pop never frees room for a same-edge push.
    assign data_ready = (level != (PW+1)'(DEPTH));
    assign push       = data_valid && data_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level <= level + (PW+1)'(1);
            else if (pop && !push) level <= level - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out       <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            out       <= out_next;
            bit_valid <= bit_valid_next;
            word_done <= word_done_next;
`ifdef SERIAL_FEEDER_PARITY_EN
            par       <= par_next;
`endif
        end
    end

    // Outputs are computed one cycle ahead so they leave the block straight from flops.
    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        cnt_next       = cnt;
        out_next       = out;
        bit_valid_next = bit_valid;
        word_done_next = word_done;
        pop            = 1'b0;
        end_frame      = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
        par_next       = par;
`endif

        case (state)
            IDLE: begin
                end_frame = 1'b1;
            end
            SHIFT: begin
                if (cnt != '0) begin
                    shreg_next = shreg << 1;
                    cnt_next   = cnt - CW'(1);
                    out_next   = shreg[WIDTH-2];
`ifdef SERIAL_FEEDER_PARITY_EN
                    word_done_next = 1'b0;
`else
                    word_done_next = (cnt == CW'(1));
`endif
                end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
                    state_next     = PARITY;
                    out_next       = par;
                    word_done_next = 1'b1;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PARITY: begin
                end_frame = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reload straight from the FIFO head so consecutive frames have no gap.
        if (end_frame) begin
            if (level != '0) begin
                pop            = 1'b1;
                shreg_next     = mem[rd_ptr];
                cnt_next       = CW'(WIDTH - 1);
                state_next     = SHIFT;
                out_next       = mem[rd_ptr][WIDTH-1];
                bit_valid_next = 1'b1;
                word_done_next = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
                par_next       = ^mem[rd_ptr];
`endif
            end else begin
                state_next     = IDLE;
                out_next       = IDLE_BIT;
                bit_valid_next = 1'b0;
                word_done_next = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=8, DEPTH=4); inputs change and outputs are sampled on falling edges.
module tb_serial_word_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       out;
    logic       bit_valid;
    logic       word_done;
    logic       busy;
    logic [2:0] level;

    int checks = 0;
    int passes = 0;

    serial_word_feeder #(.WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .out(out), .bit_valid(bit_valid),
        .word_done(word_done), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] w, input int j);
        logic b;
        if (j < 8) b = w[7-j];
        else       b = ^w;
        return b;
    endfunction

    task automatic test_reset;
        logic seen;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({out, bit_valid, busy, word_done} !== 4'b0000) $display("[TB] FAIL reset_outputs out/bv/busy/wd=%b expected 0000", {out, bit_valid, busy, word_done}); else passes++;
        checks++; if (level !== 3'd0) $display("[TB] FAIL reset_level got %0d expected 0", level); else passes++;
        checks++; if (data_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b expected 1", data_ready); else passes++;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bit_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("[TB] FAIL reset_no_stale got bit_valid seen=%b expected 0", seen); else passes++;
    endtask

    task automatic test_single_word;
        logic [7:0] w = 8'h66;
        @(negedge clk);
        data_valid = 1'b1; data_in = w;
        @(negedge clk);
        data_valid = 1'b0;
        checks++; if (bit_valid !== 1'b0 || level !== 3'd1) $display("[TB] FAIL single_latency bv=%b level=%0d expected 0/1", bit_valid, level); else passes++;
        @(negedge clk);
        for (int j = 0; j < FRAME; j++) begin
            checks++; if (out !== exp_bit(w, j) || bit_valid !== 1'b1) $display("[TB] FAIL single_bit%0d out=%b bv=%b expected %b/1", j, out, bit_valid, exp_bit(w, j)); else passes++;
            checks++; if (word_done !== (j == FRAME-1)) $display("[TB] FAIL single_done%0d got %b expected %b", j, word_done, (j == FRAME-1)); else passes++;
            @(negedge clk);
        end
        checks++; if ({out, bit_valid, busy} !== 3'b000) $display("[TB] FAIL single_idle out/bv/busy=%b expected 000", {out, bit_valid, busy}); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [2];
        words[0] = 8'h66; words[1] = 8'h0F;
        @(negedge clk);
        data_valid = 1'b1; data_in = words[0];
        @(negedge clk);
        data_in = words[1];
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 2*FRAME; i++) begin
            checks++; if (out !== exp_bit(words[i/FRAME], i%FRAME) || bit_valid !== 1'b1) $display("[TB] FAIL b2b_bit%0d out=%b bv=%b expected %b/1", i, out, bit_valid, exp_bit(words[i/FRAME], i%FRAME)); else passes++;
            checks++; if (word_done !== ((i%FRAME) == FRAME-1)) $display("[TB] FAIL b2b_done%0d got %b expected %b", i, word_done, ((i%FRAME) == FRAME-1)); else passes++;
            @(negedge clk);
        end
        checks++; if (bit_valid !== 1'b0) $display("[TB] FAIL b2b_end bv=%b expected 0", bit_valid); else passes++;
    endtask

    task automatic test_full_fifo;
        logic [7:0] words [5];
        int accepted = 0;
        logic r;
        words[0] = 8'hF0; words[1] = 8'h8F; words[2] = 8'hAA; words[3] = 8'h55; words[4] = 8'hC3;
        @(negedge clk);
        data_valid = 1'b1; data_in = words[0];
        for (int e = 1; e <= 2 + FRAME; e++) begin
            r = data_ready;
            @(negedge clk);
            if (r) begin
                accepted++;
                if (accepted < 5) data_in = words[accepted];
            end
            if (e == 5) begin
                checks++; if (level !== 3'd4 || data_ready !== 1'b0) $display("[TB] FAIL full_level level=%0d ready=%b expected 4/0", level, data_ready); else passes++;
            end
            if (e == 1 + FRAME) begin
                checks++; if (word_done !== 1'b1 || data_ready !== 1'b0) $display("[TB] FAIL full_before_pop wd=%b ready=%b expected 1/0", word_done, data_ready); else passes++;
            end
        end
        data_valid = 1'b0;
        checks++; if (accepted !== 5) $display("[TB] FAIL full_accepted got %0d expected 5", accepted); else passes++;
        checks++; if (data_ready !== 1'b1 || level !== 3'd3) $display("[TB] FAIL full_release ready=%b level=%0d expected 1/3", data_ready, level); else passes++;
        checks++; if (out !== 1'b1 || word_done !== 1'b0 || bit_valid !== 1'b1) $display("[TB] FAIL full_second_word out/wd/bv=%b expected 101", {out, word_done, bit_valid}); else passes++;
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] w = 8'hA5;
        logic [7:0] n = 8'h3C;
        logic seen;
        @(negedge clk);
        data_valid = 1'b1; data_in = w;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            checks++; if (out !== w[7-j] || bit_valid !== 1'b1) $display("[TB] FAIL midreset_bit%0d out=%b bv=%b expected %b/1", j, out, bit_valid, w[7-j]); else passes++;
            if (j < 2) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++; if ({out, bit_valid, busy} !== 3'b000 || level !== 3'd0) $display("[TB] FAIL midreset_clear out/bv/busy=%b level=%0d expected 000/0", {out, bit_valid, busy}, level); else passes++;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bit_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("[TB] FAIL midreset_resumed seen=%b expected 0", seen); else passes++;
        data_valid = 1'b1; data_in = n;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < FRAME; j++) begin
            checks++; if (out !== exp_bit(n, j) || bit_valid !== 1'b1 || word_done !== (j == FRAME-1)) $display("[TB] FAIL midreset_next%0d out/bv/wd=%b expected %b1%b", j, {out, bit_valid, word_done}, exp_bit(n, j), (j == FRAME-1)); else passes++;
            @(negedge clk);
        end
        checks++; if (bit_valid !== 1'b0) $display("[TB] FAIL midreset_end bv=%b expected 0", bit_valid); else passes++;
    endtask

`ifdef SERIAL_FEEDER_PARITY_EN
    task automatic test_parity;
        logic [8:0] expected = 9'b000001111;
        @(negedge clk);
        data_valid = 1'b1; data_in = 8'h07;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            checks++; if (out !== expected[8-j] || bit_valid !== 1'b1 || word_done !== (j == 8)) $display("[TB] FAIL parity_bit%0d out/bv/wd=%b expected %b1%b", j, {out, bit_valid, word_done}, expected[8-j], (j == 8)); else passes++;
            @(negedge clk);
        end
        checks++; if (bit_valid !== 1'b0) $display("[TB] FAIL parity_end bv=%b expected 0", bit_valid); else passes++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        data_valid = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        checks++; if ({out, bit_valid, word_done, busy} !== 4'b0000 || level !== 3'd0 || data_ready !== 1'b1) $display("[TB] FAIL init_reset out/bv/wd/busy=%b level=%0d ready=%b expected 0000/0/1", {out, bit_valid, word_done, busy}, level, data_ready); else passes++;
        @(negedge clk);
        reset = 1'b0;
        test_single_word;
        test_back_to_back;
        test_full_fifo;
        test_reset;
        test_reset_mid_word;
`ifdef SERIAL_FEEDER_PARITY_EN
        test_parity;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
